// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Segment table is active-high in {g,f,e,d,c,b,a} order.
package disp_pkg;

    localparam int SEG_W = 8;

    // Active-high "all segments dark" pattern including dp.
    localparam logic [SEG_W-1:0] SEG_OFF = '0;

    // Hex nibble to segments, entry 0 in the low slice.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to 7-segment decoder.
// Output is active-high {g,f,e,d,c,b,a}.
module hex7seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup of the nibble.
    always_comb begin
        seg = HEX_SEG[nib];
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed display scanner with double-buffered digit data,
// anti-ghost blanking and selectable output polarity.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    output logic [SEG_W-1:0]      seg_out,
    output logic [DIGITS-1:0]     sel_out,
    output logic                  frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

    localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);
    localparam logic [SEG_W-1:0]  SEG_IDLE =
        (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] SEL_IDLE =
        (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  frame_done_q, frame_done_d;
    logic                  wrap;

    logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]     pend_en_q, pend_en_d;
    logic                  pend_valid_q, pend_valid_d;

    logic [4*DIGITS-1:0]   act_data_q, act_data_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [DIGITS-1:0]     act_en_q, act_en_d;

    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [DIGITS-1:0]     sel_q, sel_d;

    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg;
    logic [SEG_W-1:0]      seg_hi;
    logic [DIGITS-1:0]     sel_hi;

    assign cur_nib = act_data_q[{idx_q, 2'b00} +: 4];

    hex7seg_decode u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    assign seg_hi = {act_dp_q[idx_q], cur_seg};
    assign sel_hi = SEL_ONE << idx_q;

    // Scan counters, frame wrap and the pending/active buffer swap.
    always_comb begin
        presc_d      = presc_q + PW'(1);
        idx_d        = idx_q;
        wrap         = 1'b0;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;

        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        frame_done_d = wrap;

        // Swap uses the pre-edge pending copy, so a load on
        // the wrap cycle waits for the following wrap.
        if (wrap && pend_valid_q) begin
            act_data_d   = pend_data_q;
            act_dp_d     = pend_dp_q;
            act_en_d     = pend_en_q;
            pend_valid_d = 1'b0;
        end

        if (load) begin
            pend_data_d  = data_in;
            pend_dp_d    = dp_in;
            pend_en_d    = digit_en;
            pend_valid_d = 1'b1;
        end
    end

    // Output pattern for the current slot, before the output register.
    always_comb begin
        seg_d = SEG_IDLE;
        sel_d = SEL_IDLE;
        if ((presc_q >= BLANK_END) && act_en_q[idx_q]) begin
            seg_d = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
            sel_d = (ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            seg_q        <= SEG_IDLE;
            sel_q        <= SEL_IDLE;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
        end
    end

    assign seg_out    = seg_q;
    assign sel_out    = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with a frame-level
// reference model built from the load history.
module tb_disp_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic [7:0]  seg_out;
    logic [3:0]  sel_out;
    logic        frame_done;

    disp_scan_ctrl #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .seg_out    (seg_out),
        .sel_out    (sel_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  en;
    } ld_t;

    ld_t q[$];

    // Common-anode (active-low) codes, dp bit high = dark.
    logic [7:0] lut [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int cmps = 0;
    int errs = 0;
    int n = 0;
    int first_fd = -1;
    int tgt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)",
                   tag, obs, exp, n);
        end
    endtask

    // Output after edge nn shows the scan state after edge nn-1.
    // The frame containing that state displays the newest load
    // sampled strictly before that frame's first edge.
    function automatic void model(input int nn,
                                  output logic [3:0] e_sel,
                                  output logic [7:0] e_seg,
                                  output logic e_fd);
        int m;
        int f;
        int pos;
        int slot;
        int off;
        logic [15:0] d;
        logic [3:0] dp;
        logic [3:0] en;
        logic [3:0] nib;
        m    = nn - 1;
        f    = m / FRAME;
        pos  = m % FRAME;
        slot = pos / SCAN_DIV;
        off  = pos % SCAN_DIV;
        d    = '0;
        dp   = '0;
        en   = '0;
        foreach (q[i]) begin
            if (q[i].e < FRAME * f) begin
                d  = q[i].d;
                dp = q[i].dp;
                en = q[i].en;
            end
        end
        e_sel = 4'hF;
        e_seg = 8'hFF;
        if (off >= BLANK_CYC && en[slot]) begin
            e_sel[slot] = 1'b0;
            nib   = d[slot*4 +: 4];
            e_seg = lut[nib];
            if (dp[slot]) e_seg[7] = 1'b0;
        end
        e_fd = (nn > 0) && (nn % FRAME == 0);
    endfunction

    task automatic step();
        logic [3:0] es;
        logic [7:0] eg;
        logic       ef;
        @(posedge clk);
        n++;
        if (load) q.push_back('{e: n, d: data_in, dp: dp_in, en: digit_en});
        #1;
        if (frame_done === 1'b1 && first_fd < 0) first_fd = n;
        model(n, es, eg, ef);
        chk("sel", 32'(sel_out), 32'(es));
        chk("seg", 32'(seg_out), 32'(eg));
        chk("frame_done", 32'(frame_done), 32'(ef));
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] en);
        data_in  = d;
        dp_in    = dp;
        digit_en = en;
        load     = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        dp_in    = '0;
        digit_en = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", 32'(sel_out), 32'hF);
        chk("rst_seg", 32'(seg_out), 32'hFF);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        n = 0;

        run_to(9);
        do_load(16'h1234, 4'h0, 4'hF);
        run_to(20);
        chk("frame0_still_blank", 32'(sel_out), 32'hF);
        run_to(35);
        chk("d0_sel", 32'(sel_out), 32'hE);
        chk("d0_seg_4", 32'(seg_out), 32'h99);
        run_to(40);
        chk("first_fd_cycle", 32'(first_fd), 32'd32);
        run_to(59);
        chk("d3_sel", 32'(sel_out), 32'h7);
        chk("d3_seg_1", 32'(seg_out), 32'hF9);

        do_load(16'h1234, 4'b0001, 4'b1011);
        run_to(67);
        chk("d0_dp_seg", 32'(seg_out), 32'h19);
        run_to(85);
        chk("d2_off_sel", 32'(sel_out), 32'hF);
        chk("d2_off_seg", 32'(seg_out), 32'hFF);

        run_to(96);
        chk("fd_at_96", 32'(frame_done), 32'h1);
        do_load(16'hABCD, 4'h0, 4'hF);
        run_to(99);
        chk("old_after_fd_load", 32'(seg_out), 32'h19);
        run_to(131);
        chk("new_abcd_d0", 32'(seg_out), 32'hA1);

        run_to(159);
        do_load(16'h5E7F, 4'h0, 4'hF);
        run_to(163);
        chk("wrap_load_deferred", 32'(seg_out), 32'hA1);
        run_to(195);
        chk("wrap_load_applied", 32'(seg_out), 32'h8E);

        repeat (320) begin
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            load     = ($urandom_range(0, 5) == 0);
            step();
        end
        load = 1'b0;

        tgt = (n / FRAME + 1) * FRAME + 2 * SCAN_DIV;
        run_to(tgt);
        do_load(16'($urandom), 4'($urandom), 4'hF);
        rst_n = 1'b0;
        #2;
        chk("midrst_sel", 32'(sel_out), 32'hF);
        chk("midrst_seg", 32'(seg_out), 32'hFF);
        chk("midrst_fd", 32'(frame_done), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_hold_sel", 32'(sel_out), 32'hF);
        rst_n = 1'b1;
        n = 0;
        first_fd = -1;
        q.delete();

        run_to(35);
        chk("pend_lost_sel", 32'(sel_out), 32'hF);
        chk("pend_lost_seg", 32'(seg_out), 32'hFF);
        run_to(40);
        chk("restart_fd_cycle", 32'(first_fd), 32'd32);
        run_to(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmps, errs);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, >= 4.
REQ-003 SHALL have parameter BLANK_CYC, default 2: anti-ghost cycles at the start of each slot, < SCAN_DIV.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = segment and select outputs active-low, 0 = active-high.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port data_in, input, 4*DIGITS: hex nibble per digit; digit k in bits [4k+3:4k].
REQ-008 SHALL have port dp_in, input, DIGITS: decimal point per digit, 1 = lit.
REQ-009 SHALL have port digit_en, input, DIGITS: per-digit enable, 0 = digit blanked.
REQ-010 SHALL have port load, input, 1: one-cycle strobe capturing data_in, dp_in and digit_en into the pending buffer.
REQ-011 SHALL have port seg_out, output, 8: {dp,g,f,e,d,c,b,a}, registered.
REQ-012 SHALL have port sel_out, output, DIGITS: one-hot digit select (one-cold if ACTIVE_LOW), registered.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse at the end of every full scan frame.

Function
REQ-014 Prescaler SHALL count 0..SCAN_DIV-1, wrapping to 0; at terminal count the digit index advances.
REQ-015 Digit index SHALL count 0..DIGITS-1 and wrap to 0; frame_done SHALL pulse on the cycle the index wraps from DIGITS-1 to 0.
REQ-016 Double buffering: load SHALL write the pending buffer and set pending_valid; multiple loads within one frame SHALL leave the last values pending.
REQ-017 Pending buffer SHALL transfer to the active buffer only at frame wrap, clearing pending_valid; the display SHALL never change mid-frame.
REQ-018 A load coinciding with the frame-wrap cycle SHALL be applied at the following wrap, not the current one.
REQ-019 During prescaler values 0..BLANK_CYC-1 of each slot, sel_out and seg_out SHALL be driven inactive.
REQ-020 Outside the blank window, sel_out SHALL assert only the current index bit, and seg_out SHALL carry the 7-segment decode of the active nibble (0-F) plus the dp bit.
REQ-021 For a digit whose active digit_en bit is 0, sel_out and seg_out SHALL remain inactive for its whole slot.
REQ-022 Outputs SHALL be registered with one cycle of latency from the prescaler/index state.
REQ-023 Inactive level SHALL be all-ones when ACTIVE_LOW=1 and all-zeros otherwise, for both sel_out and seg_out.

Reset
REQ-024 While rst_n is low, prescaler, index, pending_valid and frame_done SHALL be 0, active and pending buffers SHALL be cleared, and seg_out/sel_out SHALL be inactive.
REQ-025 Reset asserted mid-frame SHALL discard pending data; after release, scanning SHALL restart at digit 0, prescaler 0.

Structure
REQ-026 A shared package disp_pkg SHALL hold the 16-entry hex-to-segment table (active-high), SEG_W=8 and the segment-off constant.
REQ-027 Decoding SHALL live in the combinational sub-module hex7seg_decode (4-bit in, 7-bit out); polarity inversion is applied in disp_scan_ctrl.

Verification (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1)
REQ-028 Hold rst_n=0 -> sel_out=4'b1111, seg_out=8'hFF, frame_done=0; release -> first frame_done pulse exactly 32 cycles after the first post-reset prescaler count.
REQ-029 load with data_in=16'h1234, dp_in=0, digit_en=4'hF mid-frame -> unchanged until wrap; the next frame shows digit0 slot sel_out=4'b1110 with seg_out=8'h99 ('4'), and digit3 slot seg_out=8'hF9 ('1').
REQ-030 Each slot -> sel_out=4'b1111 for the first 2 output cycles, then the selected digit for 6 cycles; frame_done high for exactly 1 cycle every 32.
REQ-031 digit_en=4'b1011 -> during digit 2 slot sel_out=4'b1111 and seg_out=8'hFF for all 8 cycles; dp_in[0]=1 -> digit0 seg_out bit7=0.
REQ-032 load of 16'hABCD on the frame_done cycle -> the next frame still shows the old data; the frame after that shows 16'hABCD.
REQ-033 rst_n pulsed low during digit 2 with a pending load -> outputs inactive immediately; after release, scanning restarts at digit 0 with blank data and the pending load lost.
